// File: rtl/fp_operand_loader.sv
// Byte-serial entry of two 32-bit FP operands from 8 switches and a push-button.
// Optional button debounce is enabled with `define FP_LOADER_DEBOUNCE_EN.
module fp_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw,
    input  logic        btn,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_valid,
    output logic        op_load,
    output logic [2:0]  entry_idx
);

    typedef enum logic [1:0] {S_A, S_B, S_DONE} state_t;

    logic [7:0] sw_p0, sw_p1;
    logic       btn_p0, btn_p1;
    logic       stable, stable_d;
    logic       press;
    state_t     state;
    logic [1:0] idx;

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    // Stage p0/p1: two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_p0  <= '0;
            sw_p1  <= '0;
            btn_p0 <= 1'b0;
            btn_p1 <= 1'b0;
        end else begin
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
            btn_p0 <= btn;
            btn_p1 <= btn_p0;
        end
    end

`ifdef FP_LOADER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    logic [CNT_W-1:0] db_cnt;

    // Accept a new button level only after it has differed from the current one long enough
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            stable <= 1'b0;
        end else if (btn_p1 != stable) begin
            if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= btn_p1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
        end else begin
            stable <= btn_p1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
        end
    end

    assign press = stable & ~stable_d;

    // Entry FSM: operands shift in MSB first, one byte per accepted press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_A;
            idx      <= 2'd0;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            op_load  <= 1'b0;
        end else begin
            op_load <= 1'b0;
            if (press) begin
                case (state)
                    S_A: begin
                        op_a <= {op_a[23:0], sw_p1};
                        if (idx == 2'd3) begin
                            state <= S_B;
                            idx   <= 2'd0;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                    S_B: begin
                        op_b <= {op_b[23:0], sw_p1};
                        if (idx == 2'd3) begin
                            state    <= S_DONE;
                            idx      <= 2'd0;
                            op_valid <= 1'b1;
                            op_load  <= 1'b1;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                    default: begin
                        op_a     <= '0;
                        op_b     <= '0;
                        op_valid <= 1'b0;
                        state    <= S_A;
                        idx      <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign entry_idx = {state == S_B, idx};

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed testbench for fp_operand_loader (DEBOUNCE_CYCLES=4); adapts to FP_LOADER_DEBOUNCE_EN.
module tb_fp_operand_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  sw  = 8'h00;
    logic        btn = 1'b0;
    logic [31:0] op_a, op_b;
    logic        op_valid, op_load;
    logic [2:0]  entry_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int load_cnt = 0;

    fp_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn(btn),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
        .op_load(op_load), .entry_idx(entry_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (op_load === 1'b1) load_cnt++;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; btn = 1'b0; sw = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Clean press long enough for the debounced build, then a clean release
    task automatic press_byte(input logic [7:0] b);
        @(negedge clk);
        sw = b; btn = 1'b1;
        repeat (12) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        if (op_a !== 32'h0) begin n_fail++; $display("FAIL reset_op_a got=%h exp=%h", op_a, 32'h0); end
        n_checks++;
        if (op_b !== 32'h0) begin n_fail++; $display("FAIL reset_op_b got=%h exp=%h", op_b, 32'h0); end
        n_checks++;
        if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
        n_checks++;
        if (op_load !== 1'b0) begin n_fail++; $display("FAIL reset_op_load got=%b exp=0", op_load); end
        n_checks++;
        if (entry_idx !== 3'd0) begin n_fail++; $display("FAIL reset_entry_idx got=%0d exp=0", entry_idx); end
        n_checks++;
        do_reset();
    endtask

    task automatic test_full_entry();
        logic [7:0] bytes [8];
        bytes = '{8'h2a, 8'hc4, 8'h92, 8'h14, 8'h6a, 8'hc4, 8'h92, 8'h14};
        do_reset();
        load_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (entry_idx !== 3'(i)) begin
                n_fail++; $display("FAIL full_entry_idx[%0d] got=%0d exp=%0d", i, entry_idx, i);
            end
            n_checks++;
            if (i == 7 && op_valid !== 1'b0) begin
                n_fail++; $display("FAIL full_valid_early got=%b exp=0", op_valid);
            end
            if (i == 7) n_checks++;
            press_byte(bytes[i]);
        end
        if (entry_idx !== 3'd0) begin n_fail++; $display("FAIL full_entry_idx_done got=%0d exp=0", entry_idx); end
        n_checks++;
        if (op_a !== 32'h2ac49214) begin n_fail++; $display("FAIL full_op_a got=%h exp=%h", op_a, 32'h2ac49214); end
        n_checks++;
        if (op_b !== 32'h6ac49214) begin n_fail++; $display("FAIL full_op_b got=%h exp=%h", op_b, 32'h6ac49214); end
        n_checks++;
        if (op_valid !== 1'b1) begin n_fail++; $display("FAIL full_op_valid got=%b exp=1", op_valid); end
        n_checks++;
        if (load_cnt !== 1) begin n_fail++; $display("FAIL full_op_load_cycles got=%0d exp=1", load_cnt); end
        n_checks++;
    endtask

    task automatic test_clear();
        press_byte(8'hff);
        if (op_a !== 32'h0) begin n_fail++; $display("FAIL clear_op_a got=%h exp=%h", op_a, 32'h0); end
        n_checks++;
        if (op_b !== 32'h0) begin n_fail++; $display("FAIL clear_op_b got=%h exp=%h", op_b, 32'h0); end
        n_checks++;
        if (op_valid !== 1'b0) begin n_fail++; $display("FAIL clear_op_valid got=%b exp=0", op_valid); end
        n_checks++;
        if (entry_idx !== 3'd0) begin n_fail++; $display("FAIL clear_entry_idx got=%0d exp=0", entry_idx); end
        n_checks++;
        if (load_cnt !== 1) begin n_fail++; $display("FAIL clear_op_load_cycles got=%0d exp=1", load_cnt); end
        n_checks++;
        press_byte(8'h3c);
        if (op_a !== 32'h0000003c) begin n_fail++; $display("FAIL clear_reentry_op_a got=%h exp=%h", op_a, 32'h3c); end
        n_checks++;
    endtask

    task automatic test_held();
        do_reset();
        @(negedge clk);
        sw = 8'h5a; btn = 1'b1;
        repeat (100) @(negedge clk);
        if (entry_idx !== 3'd1) begin n_fail++; $display("FAIL held_entry_idx got=%0d exp=1", entry_idx); end
        n_checks++;
        if (op_a !== 32'h0000005a) begin n_fail++; $display("FAIL held_op_a got=%h exp=%h", op_a, 32'h5a); end
        n_checks++;
        btn = 1'b0;
        repeat (20) @(negedge clk);
        if (entry_idx !== 3'd1) begin n_fail++; $display("FAIL held_release_idx got=%0d exp=1", entry_idx); end
        n_checks++;
    endtask

    task automatic test_async_reset();
        do_reset();
        press_byte(8'h11);
        press_byte(8'h22);
        press_byte(8'h33);
        press_byte(8'h44);
        press_byte(8'h55);
        if (op_a !== 32'h11223344) begin n_fail++; $display("FAIL mid_op_a got=%h exp=%h", op_a, 32'h11223344); end
        n_checks++;
        if (op_b !== 32'h00000055) begin n_fail++; $display("FAIL mid_op_b got=%h exp=%h", op_b, 32'h55); end
        n_checks++;
        if (entry_idx !== 3'b101) begin n_fail++; $display("FAIL mid_entry_idx got=%0d exp=5", entry_idx); end
        n_checks++;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        if (op_a !== 32'h0) begin n_fail++; $display("FAIL async_op_a got=%h exp=%h", op_a, 32'h0); end
        n_checks++;
        if (op_b !== 32'h0) begin n_fail++; $display("FAIL async_op_b got=%h exp=%h", op_b, 32'h0); end
        n_checks++;
        if (entry_idx !== 3'd0) begin n_fail++; $display("FAIL async_entry_idx got=%0d exp=0", entry_idx); end
        n_checks++;
        @(negedge clk);
        rst = 1'b0;
        press_byte(8'h66);
        if (op_a !== 32'h00000066) begin n_fail++; $display("FAIL post_reset_op_a got=%h exp=%h", op_a, 32'h66); end
        n_checks++;
        if (entry_idx !== 3'd1) begin n_fail++; $display("FAIL post_reset_idx got=%0d exp=1", entry_idx); end
        n_checks++;
    endtask

`ifdef FP_LOADER_DEBOUNCE_EN
    task automatic test_glitch();
        do_reset();
        @(negedge clk);
        sw = 8'ha5; btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (20) @(negedge clk);
        if (entry_idx !== 3'd0) begin n_fail++; $display("FAIL glitch_entry_idx got=%0d exp=0", entry_idx); end
        n_checks++;
        if (op_a !== 32'h0) begin n_fail++; $display("FAIL glitch_op_a got=%h exp=%h", op_a, 32'h0); end
        n_checks++;
    endtask
`else
    task automatic test_pulse();
        logic [7:0] bytes [4];
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sw = bytes[i]; btn = 1'b1;
            @(negedge clk);
            btn = 1'b0;
            repeat (5) @(negedge clk);
        end
        if (op_a !== 32'h01020304) begin n_fail++; $display("FAIL pulse_op_a got=%h exp=%h", op_a, 32'h01020304); end
        n_checks++;
        if (entry_idx !== 3'b100) begin n_fail++; $display("FAIL pulse_entry_idx got=%0d exp=4", entry_idx); end
        n_checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_full_entry();
        test_clear();
        test_held();
`ifdef FP_LOADER_DEBOUNCE_EN
        test_glitch();
`else
        test_pulse();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
